// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: owns the PC, fetches words over a req/gnt/rvalid
// handshake, presents them via valid/ready, and resolves next-PC on consume.
module instr_fetch_seq #(
  parameter int                oplen    = 7,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [oplen-1:0]  op,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [ADDR_W-1:0] pc,
  input  logic              branch,
  input  logic              pc_signal,
  input  logic              zero,
  input  logic [ADDR_W-1:0] target,
  output logic              illegal,
  output logic              misalign_err,
  output logic [31:0]       retire_cnt
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t            state;
  logic              consume;
  logic              take;
  logic [ADDR_W-1:0] next_pc;

  // Misaligned targets are forced down to the enclosing word.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  assign consume = (state == S_HOLD) && instr_valid && instr_ready;
  assign take    = pc_signal || (branch && zero);

  always_comb begin
    next_pc = pc + ADDR_W'(4);
    if (take) next_pc = word_align(target);
  end

  // Request is suppressed combinationally so it drops the instant rst rises.
  assign imem_req  = (state == S_REQ) && !rst;
  assign imem_addr = pc;

  assign op      = instr[oplen-1:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign rd      = instr[11:7];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign illegal = (instr[1:0] != 2'b11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      instr        <= NOP;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
      retire_cnt   <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_gnt) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (consume) begin
            instr_valid <= 1'b0;
            pc          <= next_pc;
            retire_cnt  <= retire_cnt + 32'd1;
            state       <= S_REQ;
            if (take && (target[1:0] != 2'b00)) misalign_err <= 1'b1;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: vector table for fetch/decode/next-PC,
// plus hand sequences for back-pressure, wrap, counter wrap and reset mid-fetch.
module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] pc;
  logic        branch, pc_signal, zero;
  logic [31:0] target;
  logic        illegal;
  logic        misalign_err;
  logic [31:0] retire_cnt;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_seq #(.oplen(7), .ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .op(op), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .pc(pc), .branch(branch), .pc_signal(pc_signal), .zero(zero), .target(target),
    .illegal(illegal), .misalign_err(misalign_err), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] rdata;
    logic        br, ps, z;
    logic [31:0] tgt;
    logic [6:0]  e_op;
    logic [2:0]  e_f3;
    logic [6:0]  e_f7;
    logic [4:0]  e_rd, e_rs1, e_rs2;
    logic        e_ill;
    logic [31:0] e_next;
    logic        e_mis;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the DUT in REQ; returns at a negedge in HOLD.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word);
    check("req_asserted", {31'b0, imem_req}, 32'd1);
    check("req_addr", imem_addr, exp_addr);
    check("valid_low_in_req", {31'b0, instr_valid}, 32'd0);
    imem_gnt    = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    imem_gnt    = 1'b0;
    instr_ready = 1'b0;
    check("req_low_in_wait", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    check("valid_in_hold", {31'b0, instr_valid}, 32'd1);
    check("instr_word", instr, word);
  endtask

  task automatic consume(input logic br, input logic ps, input logic z, input logic [31:0] tgt,
                         input logic [31:0] exp_next, input logic exp_mis, input logic [31:0] exp_ret);
    branch = br; pc_signal = ps; zero = z; target = tgt;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    branch = 1'b0; pc_signal = 1'b0; zero = 1'b0; target = 32'h0;
    check("valid_dropped", {31'b0, instr_valid}, 32'd0);
    check("next_addr", imem_addr, exp_next);
    check("misalign_err", {31'b0, misalign_err}, {31'b0, exp_mis});
    check("retire_cnt", retire_cnt, exp_ret);
  endtask

  logic [31:0] exp_pc;
  logic [31:0] exp_ret;

  initial begin
    vt[0] = '{32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0,   7'h13, 3'd0, 7'h00, 5'd0, 5'd0,  5'd0,  1'b0, 32'h004, 1'b0};
    vt[1] = '{32'h4000_0033, 1'b0, 1'b0, 1'b0, 32'h0,   7'h33, 3'd0, 7'h20, 5'd0, 5'd0,  5'd0,  1'b0, 32'h008, 1'b0};
    vt[2] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,   7'h00, 3'd0, 7'h00, 5'd0, 5'd0,  5'd0,  1'b1, 32'h00C, 1'b0};
    vt[3] = '{32'h00A5_0463, 1'b1, 1'b0, 1'b1, 32'h100, 7'h63, 3'd0, 7'h00, 5'd8, 5'd10, 5'd10, 1'b0, 32'h100, 1'b0};
    vt[4] = '{32'h00A5_0463, 1'b1, 1'b0, 1'b0, 32'h300, 7'h63, 3'd0, 7'h00, 5'd8, 5'd10, 5'd10, 1'b0, 32'h104, 1'b0};
    vt[5] = '{32'h0000_006F, 1'b1, 1'b1, 1'b0, 32'h200, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0,  5'd0,  1'b0, 32'h200, 1'b0};
    vt[6] = '{32'hFE52_14B3, 1'b0, 1'b1, 1'b0, 32'h102, 7'h33, 3'd1, 7'h7F, 5'd9, 5'd4,  5'd5,  1'b0, 32'h100, 1'b1};
    vt[7] = '{32'h0000_0013, 1'b1, 1'b0, 1'b0, 32'h007, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0,  5'd0,  1'b0, 32'h104, 1'b1};

    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    branch = 1'b0; pc_signal = 1'b0; zero = 1'b0; target = 32'h0;
    repeat (2) @(negedge clk);

    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_op", {25'b0, op}, 32'h13);
    check("rst_pc", pc, 32'h0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    check("rst_misalign", {31'b0, misalign_err}, 32'd0);
    check("rst_retire", retire_cnt, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    exp_pc  = 32'h0;
    exp_ret = 32'd0;
    for (int i = 0; i < 8; i++) begin
      fetch(exp_pc, vt[i].rdata);
      check("op", {25'b0, op}, {25'b0, vt[i].e_op});
      check("funct3", {29'b0, funct3}, {29'b0, vt[i].e_f3});
      check("funct7", {25'b0, funct7}, {25'b0, vt[i].e_f7});
      check("rd", {27'b0, rd}, {27'b0, vt[i].e_rd});
      check("rs1", {27'b0, rs1}, {27'b0, vt[i].e_rs1});
      check("rs2", {27'b0, rs2}, {27'b0, vt[i].e_rs2});
      check("illegal", {31'b0, illegal}, {31'b0, vt[i].e_ill});
      check("pc", pc, exp_pc);
      exp_ret = exp_ret + 32'd1;
      consume(vt[i].br, vt[i].ps, vt[i].z, vt[i].tgt, vt[i].e_next, vt[i].e_mis, exp_ret);
      exp_pc = vt[i].e_next;
    end

    // Back-pressure: five stalled cycles in HOLD, consume on the sixth.
    fetch(32'h104, 32'h0050_0093);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, instr_valid}, 32'd1);
      check("bp_instr", instr, 32'h0050_0093);
      check("bp_op", {25'b0, op}, 32'h13);
      check("bp_pc", pc, 32'h104);
      check("bp_no_req", {31'b0, imem_req}, 32'd0);
      check("bp_retire", retire_cnt, 32'd8);
    end
    consume(1'b0, 1'b0, 1'b0, 32'h0, 32'h108, 1'b1, 32'd9);

    // PC wrap at the top of the address space.
    fetch(32'h108, 32'h0000_006F);
    consume(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 32'd10);
    fetch(32'hFFFF_FFFC, 32'h0000_0013);
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    consume(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'd11);

    // Retire counter wrap.
    fetch(32'h0, 32'h0000_0013);
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt;
    #1;
    check("cnt_preset", retire_cnt, 32'hFFFF_FFFF);
    @(negedge clk);
    consume(1'b0, 1'b0, 1'b0, 32'h0, 32'h4, 1'b1, 32'd0);

    // Reset asserted between edges while waiting for read data.
    check("rm_req", {31'b0, imem_req}, 32'd1);
    imem_gnt = 1'b1;
    @(posedge clk);
    #1;
    imem_gnt = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("rm_req_low", {31'b0, imem_req}, 32'd0);
    check("rm_pc", pc, 32'h0);
    check("rm_instr", instr, 32'h0000_0013);
    check("rm_misalign", {31'b0, misalign_err}, 32'd0);
    check("rm_retire", retire_cnt, 32'd0);
    check("rm_valid", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    check("stale_valid", {31'b0, instr_valid}, 32'd0);
    check("stale_instr", instr, 32'h0000_0013);
    fetch(32'h0, 32'h4000_0033);
    check("post_rst_op", {25'b0, op}, 32'h33);
    consume(1'b0, 1'b0, 1'b0, 32'h0, 32'h4, 1'b0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
